// File: rtl/scg_init_if.sv
// Command/handshake bundle between the SDRAM init sequencer, the MRS
// sequence generator and the main command arbiter.
interface scg_init_if;
  logic       mrs_start;
  logic       mrs_done;
  logic [3:0] command;
  logic       init_done;

  modport master (
    output mrs_start,
    output command,
    output init_done,
    input  mrs_done
  );

  modport slave (
    input  mrs_start,
    input  command,
    input  init_done,
    output mrs_done
  );
endinterface

// File: rtl/scg_init.sv
// SDRAM power-up sequencer: power-up idle, PRECHARGE ALL, N x AUTO REFRESH,
// then hands off to the MRS generator and latches init_done.
module scg_init #(
  parameter int POWERUP_CYCLES = 20000,
  parameter int TRP_CYCLES     = 2,
  parameter int TRFC_CYCLES    = 7,
  parameter int REFRESH_COUNT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  scg_init_if.master bus
);

  localparam int MAX_PT   = (POWERUP_CYCLES > TRP_CYCLES) ? POWERUP_CYCLES : TRP_CYCLES;
  localparam int MAX_WAIT = (MAX_PT > TRFC_CYCLES) ? MAX_PT : TRFC_CYCLES;
  localparam int WW       = $clog2(MAX_WAIT) + 1;
  localparam int RW       = $clog2(REFRESH_COUNT) + 1;

  localparam logic [WW-1:0] PU_LAST   = WW'(POWERUP_CYCLES - 1);
  localparam logic [WW-1:0] TRP_LAST  = WW'(TRP_CYCLES - 1);
  localparam logic [WW-1:0] TRFC_LAST = WW'(TRFC_CYCLES - 1);
  localparam logic [RW-1:0] REF_TOTAL = RW'(REFRESH_COUNT);

  localparam logic [3:0] CMD_NOP       = 4'd0;
  localparam logic [3:0] CMD_PRECHARGE = 4'd5;
  localparam logic [3:0] CMD_REFRESH   = 4'd6;

  typedef enum logic [2:0] {
    POWERUP_WAIT,
    PRECHARGE,
    TRP_WAIT,
    REFRESH,
    TRFC_WAIT,
    MRS_START,
    MRS_WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_last;
  logic          wait_over;
  logic [RW-1:0] ref_cnt;

  // Terminal count of the timed states; untimed states use 0 so the counter parks.
  always_comb begin
    wait_last = '0;
    case (state)
      POWERUP_WAIT: wait_last = PU_LAST;
      TRP_WAIT:     wait_last = TRP_LAST;
      TRFC_WAIT:    wait_last = TRFC_LAST;
      default:      wait_last = '0;
    endcase
  end

  assign wait_over = (wait_cnt == wait_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= POWERUP_WAIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      POWERUP_WAIT: if (wait_over) next_state = PRECHARGE;
      PRECHARGE:    next_state = TRP_WAIT;
      TRP_WAIT:     if (wait_over) next_state = REFRESH;
      REFRESH:      next_state = TRFC_WAIT;
      TRFC_WAIT: begin
        if (wait_over) next_state = (ref_cnt < REF_TOTAL) ? REFRESH : MRS_START;
      end
      MRS_START:    next_state = MRS_WAIT;
      MRS_WAIT:     if (bus.mrs_done) next_state = DONE;
      DONE:         next_state = DONE;
      default:      next_state = POWERUP_WAIT;
    endcase
  end

  // Wait counter restarts on every state change and saturates at its terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      ref_cnt  <= '0;
    end else begin
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (!wait_over) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == REFRESH) begin
        ref_cnt <= ref_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.command   = CMD_NOP;
    bus.mrs_start = 1'b0;
    bus.init_done = 1'b0;
    case (state)
      PRECHARGE: bus.command   = CMD_PRECHARGE;
      REFRESH:   bus.command   = CMD_REFRESH;
      MRS_START: bus.mrs_start = 1'b1;
      DONE:      bus.init_done = 1'b1;
      default:   bus.command   = CMD_NOP;
    endcase
  end

endmodule

// File: tb/tb_scg_init.sv
// Bench for scg_init: cycle-indexed reference model of the init timeline, a
// per-cycle compare process, pinned literal timings and a default-parameter run.
module tb_scg_init;

  localparam int P = 10;
  localparam int T = 2;
  localparam int F = 3;
  localparam int R = 2;
  localparam int M = P + 1 + T + R * (1 + F);

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_d = 1'b1;

  scg_init_if bus ();
  scg_init_if bus_d ();

  scg_init #(
    .POWERUP_CYCLES(P),
    .TRP_CYCLES(T),
    .TRFC_CYCLES(F),
    .REFRESH_COUNT(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  scg_init dut_d (
    .clk(clk),
    .rst(rst_d),
    .bus(bus_d)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int cyc      = 0;
  int done_cyc = -1;

  int precharge_seen = 0;
  int precharge_at   = -1;
  int refresh_seen   = 0;
  int start_seen     = 0;

  logic [3:0] e_cmd;
  logic       e_start;
  logic       e_done;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [3:0] exp_command(input int c);
    int first_ref;
    first_ref = P + 1 + T;
    if (c == P) return 4'd5;
    if (c >= first_ref && c < M && ((c - first_ref) % (1 + F)) == 0) return 4'd6;
    return 4'd0;
  endfunction

  // Timeline model: cycle index since release, and the cycle init_done must rise.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc      = 0;
        done_cyc = -1;
      end else begin
        if (bus.mrs_done === 1'b1 && cyc >= M + 1 && done_cyc < 0) done_cyc = cyc + 1;
        cyc = cyc + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        e_cmd   = 4'd0;
        e_start = 1'b0;
        e_done  = 1'b0;
        precharge_seen = 0;
        precharge_at   = -1;
        refresh_seen   = 0;
        start_seen     = 0;
      end else begin
        e_cmd   = exp_command(cyc);
        e_start = (cyc == M);
        e_done  = (done_cyc >= 0 && cyc >= done_cyc);
        if (bus.command == 4'd5) begin
          precharge_seen++;
          precharge_at = cyc;
        end
        if (bus.command == 4'd6) refresh_seen++;
        if (bus.mrs_start) start_seen++;
      end
      check_output("command", int'(bus.command), int'(e_cmd));
      check_output("mrs_start", int'(bus.mrs_start), int'(e_start));
      check_output("init_done", int'(bus.init_done), int'(e_done));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.mrs_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pin_literals(input int mode);
    int pc;
    int ps;
    int pd;
    pc = -1;
    ps = -1;
    pd = -1;
    if (mode == 1) begin
      case (cyc)
        9:  pc = 0;
        10: pc = 5;
        11: pc = 0;
        13: pc = 6;
        17: pc = 6;
        21: begin ps = 1; pc = 0; end
        22: ps = 0;
        23: pd = 0;
        24: pd = 1;
        default: pc = -1;
      endcase
    end else if (mode == 2) begin
      case (cyc)
        71: begin pd = 0; pc = 0; end
        73: pd = 1;
        default: pc = -1;
      endcase
    end
    if (pc >= 0 || ps >= 0 || pd >= 0) begin
      @(negedge clk);
      if (pc >= 0) check_output("pin_command", int'(bus.command), pc);
      if (ps >= 0) check_output("pin_mrs_start", int'(bus.mrs_start), ps);
      if (pd >= 0) check_output("pin_init_done", int'(bus.init_done), pd);
    end
  endtask

  task automatic apply_stimulus(input int done_at, input int noise_a, input int noise_b,
                                input int rst_at, input int end_at, input int pin_mode);
    bit rst_used;
    bit running;
    int budget;
    rst_used = (rst_at < 0);
    running  = 1'b1;
    budget   = 0;
    while (running) begin
      @(posedge clk);
      #1;
      budget++;
      if (!rst_used && cyc == rst_at) begin
        rst = 1'b1;
        bus.mrs_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rst_used = 1'b1;
      end else begin
        bus.mrs_done = (cyc == done_at || cyc == noise_a || cyc == noise_b);
        pin_literals(pin_mode);
        if (rst_used && cyc >= end_at) running = 1'b0;
      end
      if (running && budget > 5000) begin
        check_output("stimulus_budget", budget, 0);
        running = 1'b0;
      end
    end
    bus.mrs_done = 1'b0;
  endtask

  task automatic run_defaults();
    int c;
    int pre;
    int refs;
    int last_ref;
    int first_ref;
    int spacing_bad;
    int start_at;
    c = 0; pre = 0; refs = 0; last_ref = -1; first_ref = -1; spacing_bad = 0; start_at = -1;
    rst_d = 1'b1;
    bus_d.mrs_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_d = 1'b0;
    while (start_at < 0 && c < 20200) begin
      @(negedge clk);
      if (bus_d.command == 4'd5) pre++;
      if (bus_d.command == 4'd6) begin
        if (last_ref >= 0 && c - last_ref != 8) spacing_bad++;
        if (first_ref < 0) first_ref = c;
        last_ref = c;
        refs++;
      end
      if (bus_d.mrs_start) start_at = c;
      @(posedge clk);
      c++;
    end
    check_output("dflt_precharge_count", pre, 1);
    check_output("dflt_refresh_count", refs, 8);
    check_output("dflt_refresh_spacing_errors", spacing_bad, 0);
    check_output("dflt_first_refresh_cycle", first_ref, 20003);
    check_output("dflt_mrs_start_cycle", start_at, 20067);
    @(negedge clk);
    check_output("dflt_init_done_m1", int'(bus_d.init_done), 0);
    @(posedge clk);
    #1 bus_d.mrs_done = 1'b1;
    @(negedge clk);
    check_output("dflt_init_done_m2", int'(bus_d.init_done), 0);
    @(posedge clk);
    #1 bus_d.mrs_done = 1'b0;
    @(negedge clk);
    check_output("dflt_init_done_m3", int'(bus_d.init_done), 1);
    check_output("dflt_command_done", int'(bus_d.command), 0);
  endtask

  initial begin
    int done_at;
    int rst_at;
    bus.mrs_done   = 1'b0;
    bus_d.mrs_done = 1'b0;
    $display("[TB] scg_init bench start, M=%0d", M);

    rst = 1'b1;
    #1;
    @(negedge clk);
    check_output("reset_command", int'(bus.command), 0);
    check_output("reset_mrs_start", int'(bus.mrs_start), 0);
    check_output("reset_init_done", int'(bus.init_done), 0);

    // Nominal run with a 2-cycle MRS responder.
    do_reset();
    apply_stimulus(M + 2, -1, -1, -1, M + 6, 1);

    // MRS generator silent for 50 cycles.
    do_reset();
    apply_stimulus(M + 51, -1, -1, -1, M + 54, 2);

    // Stray done pulses before MRS_WAIT must not disturb the timeline.
    do_reset();
    apply_stimulus(M + 2, 5, 15, -1, M + 6, 1);

    // Asynchronous reset between edges while in DONE.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_output("async_init_done", int'(bus.init_done), 0);
    check_output("async_command", int'(bus.command), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    apply_stimulus(M + 2, -1, -1, -1, M + 6, 1);

    // Reset in the middle of TRFC_WAIT, then a full restart.
    do_reset();
    apply_stimulus(M + 2, -1, -1, 15, M + 6, 0);
    check_output("restart_precharge_cycle", precharge_at, 10);
    check_output("restart_precharge_count", precharge_seen, 1);
    check_output("restart_refresh_count", refresh_seen, R);
    check_output("restart_mrs_start_count", start_seen, 1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      done_at = M + 1 + int'($urandom_range(0, 8));
      rst_at  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, M + 8)) : -1;
      apply_stimulus(done_at, int'($urandom_range(0, M)), int'($urandom_range(0, M)),
                     rst_at, done_at + 4, 0);
    end

    run_defaults();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
